// File: rtl/ghost_dir_gen.sv
`default_nettype none
// ============================================================================
// Module      : ghost_dir_gen
// Description : Per-frame ghost direction generator. Holds a direction for a
//               fixed number of frames, re-decides on walls or expiry, and
//               alternates between SCATTER (pseudo-random) and CHASE
//               (steer toward pacman) modes on one-second pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module ghost_dir_gen #(
  parameter int          HOLD_FRAMES  = 16,
  parameter int          SCATTER_SECS = 7,
  parameter int          CHASE_SECS   = 20,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       restart,
  input  logic       sec,
  input  logic [9:0] ghostX,
  input  logic [9:0] ghostY,
  input  logic [9:0] pacX,
  input  logic [9:0] pacY,
  input  logic [4:0] mapL,
  input  logic [4:0] mapR,
  input  logic [4:0] mapB,
  input  logic [4:0] mapT,
  output logic [7:0] randomkeycode,
  output logic       chase
);

  localparam logic [7:0] c_KEY_NONE = 8'h00;
  localparam logic [7:0] c_KEY_L    = 8'h04;
  localparam logic [7:0] c_KEY_R    = 8'h07;
  localparam logic [7:0] c_KEY_D    = 8'h16;
  localparam logic [7:0] c_KEY_U    = 8'h1A;

  localparam logic [0:0] c_ST_SCATTER = 1'b0;
  localparam logic [0:0] c_ST_CHASE   = 1'b1;

  localparam int c_HW   = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int c_SMAX = (SCATTER_SECS > CHASE_SECS) ? SCATTER_SECS : CHASE_SECS;
  localparam int c_SW   = (c_SMAX > 1) ? $clog2(c_SMAX) : 1;

  localparam logic [c_HW-1:0] c_HOLD_INIT  = c_HW'(HOLD_FRAMES - 1);
  localparam logic [c_SW-1:0] c_SCAT_LAST  = c_SW'(SCATTER_SECS - 1);
  localparam logic [c_SW-1:0] c_CHASE_LAST = c_SW'(CHASE_SECS - 1);

  logic [15:0]     r_lfsr;
  logic [7:0]      r_code;
  logic [c_HW-1:0] r_hold;
  logic [0:0]      r_state;
  logic [c_SW-1:0] r_sec_cnt;
  logic            r_force;
  logic            r_waiver;

  logic [15:0] w_lfsr_nxt;
  logic        w_cur_valid;
  logic [1:0]  w_cur_idx;
  logic [3:0]  w_open;
  logic [3:0]  w_rev_mask;
  logic [3:0]  w_cand;
  logic        w_decide;
  logic        w_flip;
  logic [2:0]  w_scat;
  logic [10:0] w_dx, w_dy, w_adx, w_ady;
  logic        w_prim_ok, w_sec_ok;
  logic [1:0]  w_prim_idx, w_sec_idx;
  logic        w_choice_ok;
  logic [1:0]  w_choice_idx;
  logic [7:0]  w_choice;

  // First candidate found scanning upward (mod 4) from start; {found, index}.
  function automatic logic [2:0] f_scatter(input logic [3:0] cand, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (cand[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [7:0] f_code(input logic [1:0] idx);
    case (idx)
      2'd0:    return c_KEY_L;
      2'd1:    return c_KEY_R;
      2'd2:    return c_KEY_D;
      default: return c_KEY_U;
    endcase
  endfunction

  // Next LFSR value; the lock-up state recovers by reloading the seed.
  always_comb begin
    if (r_lfsr == 16'h0000) w_lfsr_nxt = LFSR_SEED;
    else                    w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  // Map the held key code back to a direction index.
  always_comb begin
    w_cur_valid = 1'b1;
    w_cur_idx   = 2'd0;
    case (r_code)
      c_KEY_L: w_cur_idx = 2'd0;
      c_KEY_R: w_cur_idx = 2'd1;
      c_KEY_D: w_cur_idx = 2'd2;
      c_KEY_U: w_cur_idx = 2'd3;
      default: w_cur_valid = 1'b0;
    endcase
  end

  assign w_open     = {mapT == 5'd0, mapB == 5'd0, mapR == 5'd0, mapL == 5'd0};
  // Reverse pairs differ only in bit 0 of the index (L/R, D/U).
  assign w_rev_mask = w_cur_valid ? (4'b0001 << (w_cur_idx ^ 2'd1)) : 4'b0000;
  // Reversing is allowed when it is the only way out or right after a mode change.
  assign w_cand     = (!r_waiver && (|(w_open & ~w_rev_mask))) ? (w_open & ~w_rev_mask) : w_open;

  assign w_decide = (r_hold == '0) | ~w_cur_valid | ~w_open[w_cur_idx] | r_force;
  assign w_flip   = sec & ((r_state == c_ST_CHASE) ? (r_sec_cnt == c_CHASE_LAST)
                                                   : (r_sec_cnt == c_SCAT_LAST));
  assign w_scat   = f_scatter(w_cand, w_lfsr_nxt[1:0]);

  assign w_dx  = {1'b0, pacX} - {1'b0, ghostX};
  assign w_dy  = {1'b0, pacY} - {1'b0, ghostY};
  assign w_adx = w_dx[10] ? (11'd0 - w_dx) : w_dx;
  assign w_ady = w_dy[10] ? (11'd0 - w_dy) : w_dy;

  // Rank the two axes toward pacman; larger offset first, ties go horizontal.
  always_comb begin
    w_prim_ok  = 1'b0;
    w_prim_idx = 2'd0;
    w_sec_ok   = 1'b0;
    w_sec_idx  = 2'd0;
    if ((w_dx != 11'd0) && (w_adx >= w_ady)) begin
      w_prim_ok  = 1'b1;
      w_prim_idx = w_dx[10] ? 2'd0 : 2'd1;
      w_sec_ok   = (w_dy != 11'd0);
      w_sec_idx  = w_dy[10] ? 2'd3 : 2'd2;
    end else if (w_dy != 11'd0) begin
      w_prim_ok  = 1'b1;
      w_prim_idx = w_dy[10] ? 2'd3 : 2'd2;
      w_sec_ok   = (w_dx != 11'd0);
      w_sec_idx  = w_dx[10] ? 2'd0 : 2'd1;
    end
  end

  // Pick the next direction: chase preferences first, random scan as fallback.
  always_comb begin
    w_choice_ok  = w_scat[2];
    w_choice_idx = w_scat[1:0];
    if (r_state == c_ST_CHASE) begin
      if (w_prim_ok && w_cand[w_prim_idx]) begin
        w_choice_ok  = 1'b1;
        w_choice_idx = w_prim_idx;
      end else if (w_sec_ok && w_cand[w_sec_idx]) begin
        w_choice_ok  = 1'b1;
        w_choice_idx = w_sec_idx;
      end
    end
    w_choice = w_choice_ok ? f_code(w_choice_idx) : c_KEY_NONE;
  end

  // Free-running LFSR; restart deliberately leaves it alone.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= w_lfsr_nxt;
  end

  // Mode FSM counting second pulses in the current mode.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= c_ST_SCATTER;
      r_sec_cnt <= '0;
    end else if (restart) begin
      r_state   <= c_ST_SCATTER;
      r_sec_cnt <= '0;
    end else if (w_flip) begin
      r_state   <= (r_state == c_ST_CHASE) ? c_ST_SCATTER : c_ST_CHASE;
      r_sec_cnt <= '0;
    end else if (sec) begin
      r_sec_cnt <= r_sec_cnt + 1'b1;
    end
  end

  // Direction register, hold timer and the force/waiver flags.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_code   <= c_KEY_NONE;
      r_hold   <= '0;
      r_force  <= 1'b1;
      r_waiver <= 1'b0;
    end else if (restart) begin
      r_code   <= c_KEY_NONE;
      r_hold   <= '0;
      r_force  <= 1'b1;
      r_waiver <= 1'b0;
    end else begin
      if (w_decide) begin
        r_code   <= w_choice;
        r_hold   <= c_HOLD_INIT;
        r_force  <= 1'b0;
        r_waiver <= 1'b0;
      end else if (r_hold != '0) begin
        r_hold <= r_hold - 1'b1;
      end
      // A mode change wins over a same-frame decision so the new mode decides next frame.
      if (w_flip) begin
        r_force  <= 1'b1;
        r_waiver <= 1'b1;
      end
    end
  end

  assign randomkeycode = r_code;
  assign chase         = (r_state == c_ST_CHASE);

endmodule
`default_nettype wire

// File: tb/tb_ghost_dir_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_ghost_dir_gen
// Description : Self-checking bench for ghost_dir_gen: directed vector table,
//               mode/restart sequences and randomized frames against a
//               behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ghost_dir_gen;

  localparam int HOLD = 16;
  localparam int SCAT = 7;
  localparam int CHS  = 20;
  localparam int SEED = 'hACE1;

  logic       frame_clk = 1'b0;
  logic       Reset     = 1'b1;
  logic       restart   = 1'b0;
  logic       sec       = 1'b0;
  logic [9:0] ghostX, ghostY, pacX, pacY;
  logic [4:0] mapL, mapR, mapB, mapT;
  logic [7:0] randomkeycode;
  logic       chase;

  ghost_dir_gen #(
    .HOLD_FRAMES  (HOLD),
    .SCATTER_SECS (SCAT),
    .CHASE_SECS   (CHS),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .restart       (restart),
    .sec           (sec),
    .ghostX        (ghostX),
    .ghostY        (ghostY),
    .pacX          (pacX),
    .pacY          (pacY),
    .mapL          (mapL),
    .mapR          (mapR),
    .mapB          (mapB),
    .mapT          (mapT),
    .randomkeycode (randomkeycode),
    .chase         (chase)
  );

  always #5 frame_clk = ~frame_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: direction as index 0..3 (L,R,D,U) or -1 for none.
  int dir_code [4] = '{32'h04, 32'h07, 32'h16, 32'h1A};
  int m_lfsr, m_code, m_hold, m_sec;
  bit m_chase, m_force, m_waiver;

  typedef struct {
    logic [4:0] ml, mr, mb, mt;
    int         reps;
    logic [7:0] exp_code;
    logic       exp_chase;
  } vec_t;
  vec_t vecs [6];

  function automatic int code_of(input int idx);
    return (idx < 0) ? 0 : dir_code[idx];
  endfunction

  function automatic int lfsr_adv(input int v);
    int b;
    if (v == 0) return SEED;
    b = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v << 1) & 'hFFFF) | b;
  endfunction

  task automatic model_reset();
    m_lfsr = SEED; m_code = -1; m_hold = 0; m_sec = 0;
    m_chase = 0;   m_force = 1; m_waiver = 0;
  endtask

  task automatic model_step();
    int nl, dx, dy, adx, ady, p0, p1, choice, others, d, limit;
    bit open [4];
    bit cand [4];
    bit dec, flip;
    nl = lfsr_adv(m_lfsr);
    open[0] = (mapL == 0); open[1] = (mapR == 0);
    open[2] = (mapB == 0); open[3] = (mapT == 0);
    if (restart) begin
      m_code = -1; m_hold = 0; m_chase = 0; m_sec = 0; m_force = 1; m_waiver = 0;
      m_lfsr = nl;
      return;
    end
    dec   = (m_hold == 0) || (m_code < 0) || !open[(m_code < 0) ? 0 : m_code] || m_force;
    limit = m_chase ? CHS : SCAT;
    flip  = sec && (m_sec == limit - 1);
    if (dec) begin
      for (int i = 0; i < 4; i++) cand[i] = open[i];
      if (m_code >= 0 && !m_waiver) begin
        others = 0;
        for (int i = 0; i < 4; i++) if (open[i] && i != (m_code ^ 1)) others++;
        if (others > 0) cand[m_code ^ 1] = 0;
      end
      choice = -1;
      if (m_chase) begin
        dx = int'(pacX) - int'(ghostX);
        dy = int'(pacY) - int'(ghostY);
        adx = (dx < 0) ? -dx : dx;
        ady = (dy < 0) ? -dy : dy;
        if (dx != 0 && adx >= ady) begin
          p0 = (dx > 0) ? 1 : 0;
          p1 = (dy != 0) ? ((dy > 0) ? 2 : 3) : -1;
        end else if (dy != 0) begin
          p0 = (dy > 0) ? 2 : 3;
          p1 = (dx != 0) ? ((dx > 0) ? 1 : 0) : -1;
        end else begin
          p0 = -1; p1 = -1;
        end
        if (p0 >= 0 && cand[p0])      choice = p0;
        else if (p1 >= 0 && cand[p1]) choice = p1;
      end
      if (choice < 0) begin
        for (int k = 0; k < 4; k++) begin
          d = ((nl & 3) + k) % 4;
          if (choice < 0 && cand[d]) choice = d;
        end
      end
      m_code = choice; m_hold = HOLD - 1; m_force = 0; m_waiver = 0;
    end else if (m_hold > 0) begin
      m_hold--;
    end
    if (flip) begin
      m_chase = !m_chase; m_sec = 0; m_force = 1; m_waiver = 1;
    end else if (sec) begin
      m_sec++;
    end
    m_lfsr = nl;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One frame: model follows the same edge, outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge frame_clk);
    model_step();
    #1;
    check("model_code",  {24'd0, randomkeycode}, code_of(m_code));
    check("model_chase", {31'd0, chase},         {31'd0, m_chase});
  endtask

  task automatic set_maps(input logic [4:0] l, input logic [4:0] r, input logic [4:0] b, input logic [4:0] t);
    mapL = l; mapR = r; mapB = b; mapT = t;
  endtask

  task automatic pulse_sec(input int n);
    for (int i = 0; i < n; i++) begin
      sec = 1'b1; tick();
      sec = 1'b0; tick();
    end
  endtask

  function automatic logic [4:0] rand_map();
    return ($urandom_range(1) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
  endfunction

  initial begin
    ghostX = 10'd100; ghostY = 10'd100; pacX = 10'd300; pacY = 10'd120;
    set_maps(5'd0, 5'd0, 5'd0, 5'd0);

    vecs[0] = '{5'd0,  5'd0,  5'd0,  5'd0,  16, 8'h1A, 1'b0};
    vecs[1] = '{5'd0,  5'h10, 5'h01, 5'h08, 3,  8'h04, 1'b0};
    vecs[2] = '{5'h02, 5'd0,  5'h1F, 5'h04, 2,  8'h07, 1'b0};
    vecs[3] = '{5'h01, 5'h01, 5'h01, 5'h01, 2,  8'h00, 1'b0};
    vecs[4] = '{5'h11, 5'h03, 5'd0,  5'h18, 2,  8'h16, 1'b0};
    vecs[5] = '{5'd0,  5'd0,  5'd0,  5'd0,  2,  8'h16, 1'b0};

    Reset = 1'b1;
    repeat (2) @(posedge frame_clk);
    #1;
    check("reset_code",  {24'd0, randomkeycode}, 32'h00);
    check("reset_chase", {31'd0, chase},         32'h0);
    model_reset();
    Reset = 1'b0;

    // Directed table from reset: hold, wall bounce, reverse-only, boxed in, reopen.
    foreach (vecs[v]) begin
      set_maps(vecs[v].ml, vecs[v].mr, vecs[v].mb, vecs[v].mt);
      for (int r = 0; r < vecs[v].reps; r++) begin
        tick();
        check("tbl_code",  {24'd0, randomkeycode}, {24'd0, vecs[v].exp_code});
        check("tbl_chase", {31'd0, chase},         {31'd0, vecs[v].exp_chase});
      end
    end

    // Asynchronous reset in mid-frame clears outputs without a clock edge.
    #2 Reset = 1'b1;
    #1;
    check("async_rst_code",  {24'd0, randomkeycode}, 32'h00);
    check("async_rst_chase", {31'd0, chase},         32'h0);
    #1 Reset = 1'b0;
    model_reset();

    // Enter CHASE; forced decision heads right toward pacman.
    set_maps(5'd0, 5'd0, 5'd0, 5'd0);
    pulse_sec(SCAT);
    check("chase_on",         {31'd0, chase},         32'h1);
    check("chase_first_code", {24'd0, randomkeycode}, 32'h07);

    // Restart mid-hold in CHASE.
    tick(); tick();
    restart = 1'b1; tick();
    check("restart_code",  {24'd0, randomkeycode}, 32'h00);
    check("restart_chase", {31'd0, chase},         32'h0);
    restart = 1'b0; tick();

    // Full mode cycle after restart.
    pulse_sec(SCAT);
    check("chase_on_2", {31'd0, chase}, 32'h1);
    pulse_sec(CHS);
    check("chase_off",  {31'd0, chase}, 32'h0);

    // Randomized frames against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) set_maps(rand_map(), rand_map(), rand_map(), rand_map());
      if ($urandom_range(15) == 0) begin
        ghostX = 10'($urandom_range(1023));
        ghostY = 10'($urandom_range(1023));
        pacX   = ($urandom_range(3) == 0) ? ghostX : 10'($urandom_range(1023));
        pacY   = ($urandom_range(3) == 0) ? ghostY : 10'($urandom_range(1023));
      end
      sec     = ($urandom_range(7) == 0);
      restart = ($urandom_range(299) == 0);
      tick();
    end
    sec = 1'b0; restart = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ghost_dir_gen.md
GHOST_DIR_GEN -- requirements
Module: ghost_dir_gen

Interface
REQ-001 Parameter HOLD_FRAMES, default 16: frames a chosen direction is held before re-decision.
REQ-002 Parameter SCATTER_SECS, default 7: sec pulses spent in SCATTER mode.
REQ-003 Parameter CHASE_SECS, default 20: sec pulses spent in CHASE mode.
REQ-004 Parameter LFSR_SEED, default 16'hACE1: LFSR load value; never zero.
REQ-005 frame_clk  in  1  clock; one edge per video frame.
REQ-006 Reset  in  1  asynchronous, active-high reset.
REQ-007 restart  in  1  synchronous level; re-initialise game state.
REQ-008 sec  in  1  one-frame pulse, once per second, frame_clk domain.
REQ-009 ghostX, ghostY  in  10 each  current ghost centre.
REQ-010 pacX, pacY  in  10 each  current pacman centre.
REQ-011 mapL, mapR, mapB, mapT  in  5 each  wall probe per side; zero = open, nonzero = wall.
REQ-012 randomkeycode  out  8  direction code: 8'h04 L, 8'h07 R, 8'h16 D, 8'h1A U, 8'h00 none.
REQ-013 chase  out  1  1 = CHASE mode, 0 = SCATTER mode.

Function
REQ-014 Reset is asynchronous, active-high; clock is frame_clk; all state updates on rising frame_clk.
REQ-015 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every frame; if ever zero, reloads LFSR_SEED on the next frame.
REQ-016 Direction index order: 0=L, 1=R, 2=D, 3=U; reverse pairs L/R and D/U.
REQ-017 Open set = directions whose map input is zero; candidate set = open set minus reverse of current code, unless the reverse is the only open direction or the reverse waiver (REQ-024) is active.
REQ-018 Decide condition, evaluated each frame: hold_cnt == 0, OR current code's map input nonzero, OR current code == 8'h00, OR force flag set.
REQ-019 On decide: randomkeycode <= choice, hold_cnt <= HOLD_FRAMES-1, force flag cleared; otherwise hold_cnt decrements (saturating at 0) and code holds.
REQ-020 Choice with empty candidate set: 8'h00.
REQ-021 SCATTER choice: scan indices starting at lfsr[1:0], ascending mod 4; first candidate wins.
REQ-022 CHASE choice: dx = pacX - ghostX, dy = pacY - ghostY, 11-bit signed; primary axis = horizontal if |dx| >= |dy| and dx != 0, else vertical (dy != 0); primary dir toward pacman; fall back to secondary axis toward pacman; fall back to SCATTER rule. Only candidates eligible.
REQ-023 Mode FSM: SCATTER -> CHASE after SCATTER_SECS sec pulses; CHASE -> SCATTER after CHASE_SECS pulses; counter clears on each transition.
REQ-024 On mode transition: force flag set and reverse waiver active for the next decision only.
REQ-025 Latency: map/position inputs at edge N affect randomkeycode after edge N (registered output, one frame).
REQ-026 sec and decision in the same frame: mode transition takes effect and forces decision the following frame.

Reset
REQ-027 Reset or restart: randomkeycode = 8'h00, chase = 0, hold_cnt = 0, sec counter = 0, force flag = 1.
REQ-028 LFSR loads LFSR_SEED on Reset only; restart leaves the LFSR running.
REQ-029 restart has priority over all other non-reset updates.

Verification
REQ-030 Reset, all maps 0, SCATTER, LFSR_SEED -> first frame code equals index lfsr[1:0] of seed-advanced LFSR; code stable for 16 frames.
REQ-031 Code 8'h04 held, mapL goes nonzero mid-hold, mapR only other open -> next frame code 8'h07 (reverse allowed, only open).
REQ-032 CHASE, ghost (100,100), pac (300,120), all open, current 8'h1A -> decision yields 8'h07.
REQ-033 All four maps nonzero -> code 8'h00 next frame; mapD cleared -> 8'h16 next frame.
REQ-034 Seven sec pulses -> chase = 1 and forced decision may reverse current code; 20 more pulses -> chase = 0.
REQ-035 Assert restart mid-hold in CHASE -> next frame code 8'h00, chase 0; LFSR value not reset to seed.
